// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared width default and FSM state encoding for the gcd block
// Contents: GCD_WIDTH (default operand/result width), gcd_state_t with the
// IDLE / CALC / DONE state constants used by the control FSM.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef logic [1:0] gcd_state_t;

  localparam gcd_state_t IDLE = 2'd0;
  localparam gcd_state_t CALC = 2'd1;
  localparam gcd_state_t DONE = 2'd2;

endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - operand registers, comparator and subtractor for gcd
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears ra/rb)
//   load            capture a/b into ra/rb
//   step            one subtraction step: reduce the larger register by the smaller
//   a, b            operands (sampled only when load=1)
//   ra              current value of ra (the result once ra == rb)
//   any_zero        ra == 0 or rb == 0
//   equal           ra == rb
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ra,
  output logic             any_zero,
  output logic             equal
);

  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;

  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    if (load) begin
      ra_d = a;
      rb_d = b;
    end else if (step) begin
      // Only the larger value is reduced, so the difference never wraps.
      if (ra_q > rb_q) begin
        ra_d = ra_q - rb_q;
      end else begin
        rb_d = rb_q - ra_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra       = ra_q;
  assign any_zero = (ra_q == '0) || (rb_q == '0);
  assign equal    = (ra_q == rb_q);

endmodule

// File: rtl/gcd.sv
// rtl/gcd.sv - subtractive GCD engine with IDLE/CALC/DONE control FSM
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   a, b        unsigned operands, captured on the edge that accepts start
//   start       begin a computation; honoured only in IDLE
//   y           registered result, held until the next completion
//   done        registered one-cycle completion pulse (high while in DONE)
//   error       registered flag, 1 when an operand was zero; held like y
module gcd
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             done,
  output logic             error
);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             load;
  logic             step;
  logic [WIDTH-1:0] ra;
  logic             any_zero;
  logic             equal;

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .a       (a),
    .b       (b),
    .ra      (ra),
    .any_zero(any_zero),
    .equal   (equal)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    error_d = error_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // Zero check comes first so a=b=0 reports an error, not a result.
        if (any_zero) begin
          y_d     = '0;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (equal) begin
          y_d     = ra;
          error_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        // done_q was set on entry; it drops as we leave.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign y     = y_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_gcd.sv
// tb/tb_gcd.sv - scoreboard bench for gcd with directed hand-computed vectors
module tb_gcd;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] y;
  logic         done;
  logic         error;

  always #5 clk = ~clk;

  gcd #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .start(start),
    .y    (y),
    .done (done),
    .error(error)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int unsigned  at;
    string        name;
  } exp_t;

  exp_t sb[$];
  logic done_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input string name, input logic [W-1:0] ey, input logic ee, input int k);
    exp_t e;
    e.y    = ey;
    e.err  = ee;
    e.at   = cyc + k + 1;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done within 400 cycles, required a done pulse", name);
      sb.delete();
    end
  endtask

  // One-cycle start pulse, operands scrambled after the accepting edge.
  task automatic run(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [W-1:0] ey, input logic ee, input int k);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hA5;
    b     = 8'h5A;
    push(name, ey, ee, k);
    wait_done(name);
  endtask

  // Monitor: every done pulse pops one expectation and checks value and timing.
  always @(negedge clk) begin
    if (done) begin : mon
      exp_t e;
      chk("done_single_cycle", longint'(done_prev), 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 y=%0d, required no pending computation", y);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_y"}, longint'(y), longint'(e.y));
        chk({e.name, "_error"}, longint'(error), longint'(e.err));
        chk({e.name, "_latency"}, longint'(cyc), longint'(e.at));
      end
    end
    done_prev = done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("reset_y", longint'(y), 0);
      chk("reset_done", longint'(done), 0);
      chk("reset_error", longint'(error), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_y", longint'(y), 0);
      chk("idle_done", longint'(done), 0);
      chk("idle_error", longint'(error), 0);
    end

    run("g6_21", 8'd6, 8'd21, 8'd3, 1'b0, 4);
    run("g5_15", 8'd5, 8'd15, 8'd5, 1'b0, 2);
    repeat (6) begin
      @(negedge clk);
      chk("y_hold", longint'(y), 5);
      chk("error_hold", longint'(error), 0);
    end

    run("z0_15", 8'd0, 8'd15, 8'd0, 1'b1, 0);
    run("z17_0", 8'd17, 8'd0, 8'd0, 1'b1, 0);
    run("z0_0", 8'd0, 8'd0, 8'd0, 1'b1, 0);
    run("g9_9", 8'd9, 8'd9, 8'd9, 1'b0, 0);

    // Worst case, with start pulses during CALC that must be ignored.
    @(negedge clk);
    a     = 8'd1;
    b     = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push("g1_255", 8'd1, 1'b0, 254);
    for (int i = 0; i < 3; i++) begin
      repeat (40) @(negedge clk);
      a     = 8'd3;
      b     = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("g1_255");

    // start held high: accepted again only after DONE returns to IDLE.
    @(negedge clk);
    a     = 8'd8;
    b     = 8'd12;
    start = 1'b1;
    @(negedge clk);
    push("b2b_first", 8'd4, 1'b0, 2);
    repeat (5) @(negedge clk);
    start = 1'b0;
    push("b2b_second", 8'd4, 1'b0, 2);
    wait_done("b2b_second");

    // Reset in the middle of CALC: outputs clear without a clock edge.
    @(negedge clk);
    a     = 8'd1;
    b     = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", longint'(y), 0);
    chk("async_rst_done", longint'(done), 0);
    chk("async_rst_error", longint'(error), 0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_done", longint'(done), 0);
    end
    rst_n = 1'b1;
    a     = 8'd12;
    b     = 8'd18;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push("post_rst_12_18", 8'd6, 1'b0, 2);
    wait_done("post_rst_12_18");

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
